// File: rtl/bsg_tag_tx_pkg.sv
// Shared types and constants for the bsg_tag transmit serializer.
// Holds the local-client geometry, the derived field widths, the FSM state
// encoding, the parallel command struct and the packet-length helper.
package bsg_tag_tx_pkg;

    // Local tag client geometry of this chip (osc, dly and mon clients).
    localparam int bsg_chip_tag_local_els_gp          = 7;
    localparam int bsg_chip_tag_max_payload_width_gp  = 3;

    localparam int max_payload_width_lp = bsg_chip_tag_max_payload_width_gp;
    localparam int id_width_lp          = $clog2(bsg_chip_tag_local_els_gp);
    localparam int len_width_lp         = $clog2(max_payload_width_lp + 1);

    // Start bit, len, data_not_reset and node_id are always sent.
    localparam int header_bits_lp       = 1 + len_width_lp + 1 + id_width_lp;
    localparam int max_packet_bits_lp   = header_bits_lp + max_payload_width_lp;
    localparam int bit_cnt_width_lp     = $clog2(max_packet_bits_lp + 1);
    localparam int gap_cnt_width_lp     = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_e;

    typedef struct packed {
        logic [len_width_lp-1:0]         len;
        logic                            data_not_reset;
        logic [id_width_lp-1:0]          node_id;
        logic [max_payload_width_lp-1:0] payload;
    } bsg_tag_tx_cmd_s;

    // Total number of serial bits for a packet carrying len payload bits.
    function automatic logic [bit_cnt_width_lp-1:0] packet_bits(input logic [len_width_lp-1:0] len);
        return bit_cnt_width_lp'(header_bits_lp) + bit_cnt_width_lp'(len);
    endfunction

endpackage

// File: rtl/bsg_tag_tx_serializer_if.sv
// Command handshake between the configuration source and the tag serializer.
//   v              source -> serializer  command valid
//   ready_and      serializer -> source  command can be taken this cycle
//   node_id        destination client index
//   data_not_reset 1 = data packet, 0 = client reset packet
//   len            payload bit count
//   payload        payload, LSB-aligned
interface bsg_tag_tx_serializer_if;
    import bsg_tag_tx_pkg::*;

    logic                            v;
    logic                            ready_and;
    logic [id_width_lp-1:0]          node_id;
    logic                            data_not_reset;
    logic [len_width_lp-1:0]         len;
    logic [max_payload_width_lp-1:0] payload;

    modport master (output v, node_id, data_not_reset, len, payload, input ready_and);
    modport slave  (input v, node_id, data_not_reset, len, payload, output ready_and);

endinterface

// File: rtl/bsg_tag_tx_pack.sv
// Combinational packer for one bsg_tag command.
//   cmd_i    parallel command fields
//   word_o   packet bits, bit 0 is transmitted first
//   n_bits_o number of bits in the packet
//   legal_o  command addresses an existing client with a legal length
module bsg_tag_tx_pack
    import bsg_tag_tx_pkg::*;
#(
    parameter int els_p               = bsg_chip_tag_local_els_gp,
    parameter int max_payload_width_p = bsg_chip_tag_max_payload_width_gp
) (
    input  bsg_tag_tx_cmd_s                cmd_i,
    output logic [max_packet_bits_lp-1:0]  word_o,
    output logic [bit_cnt_width_lp-1:0]    n_bits_o,
    output logic                           legal_o
);

    logic [max_payload_width_lp-1:0] payload_mask;

    // Payload bits at or above len are zeroed so they can never leak onto
    // the line even though the shift word always has room for them.
    always_comb begin
        payload_mask = '0;
        for (int i = 0; i < max_payload_width_lp; i++) begin
            payload_mask[i] = (i < int'(cmd_i.len));
        end
        word_o   = {cmd_i.payload & payload_mask, cmd_i.node_id,
                    cmd_i.data_not_reset, cmd_i.len, 1'b1};
        n_bits_o = packet_bits(cmd_i.len);
        legal_o  = (int'(cmd_i.len) <= max_payload_width_p) &&
                   (int'(cmd_i.node_id) < els_p);
    end

endmodule

// File: rtl/bsg_tag_tx_serializer.sv
// Transmit end of the bsg_tag serial protocol.
//   clk_i       tag clock
//   reset_i     asynchronous active-high reset
//   cmd_if      command handshake (slave side)
//   tag_data_o  serial tag line, idle low, registered
//   busy_o      packet or trailing gap in progress
//   err_o       one-cycle pulse after a rejected command was taken
module bsg_tag_tx_serializer
    import bsg_tag_tx_pkg::*;
#(
    parameter int els_p               = bsg_chip_tag_local_els_gp,
    parameter int max_payload_width_p = bsg_chip_tag_max_payload_width_gp,
    parameter int gap_p               = 2
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    bsg_tag_tx_serializer_if.slave  cmd_if,
    output logic                    tag_data_o,
    output logic                    busy_o,
    output logic                    err_o
);

    localparam logic [gap_cnt_width_lp-1:0] gap_last_lp =
        (gap_p > 0) ? gap_cnt_width_lp'(gap_p - 1) : '0;

    state_e                          state_q, state_d;
    logic [max_packet_bits_lp-1:0]   shift_q, shift_d;
    logic [bit_cnt_width_lp-1:0]     bit_cnt_q, bit_cnt_d;
    logic [gap_cnt_width_lp-1:0]     gap_cnt_q, gap_cnt_d;
    logic                            tag_data_q, tag_data_d;
    logic                            busy_q, busy_d;
    logic                            err_q, err_d;

    bsg_tag_tx_cmd_s                 cmd;
    logic [max_packet_bits_lp-1:0]   word;
    logic [bit_cnt_width_lp-1:0]     n_bits;
    logic                            legal;

    always_comb begin
        cmd.len            = cmd_if.len;
        cmd.data_not_reset = cmd_if.data_not_reset;
        cmd.node_id        = cmd_if.node_id;
        cmd.payload        = cmd_if.payload;
    end

    bsg_tag_tx_pack #(
        .els_p               (els_p),
        .max_payload_width_p (max_payload_width_p)
    ) pack (
        .cmd_i    (cmd),
        .word_o   (word),
        .n_bits_o (n_bits),
        .legal_o  (legal)
    );

    // Next state and outputs. The start bit is loaded into the output flop at
    // the accept edge, so bit_cnt holds the number of bits still to follow the
    // one currently on the line; the packet ends when it reads zero.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        tag_data_d = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_if.v) begin
                    if (legal) begin
                        state_d    = SHIFT;
                        tag_data_d = word[0];
                        shift_d    = word >> 1;
                        bit_cnt_d  = n_bits - bit_cnt_width_lp'(1);
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (bit_cnt_q != '0) begin
                    tag_data_d = shift_q[0];
                    shift_d    = shift_q >> 1;
                    bit_cnt_d  = bit_cnt_q - bit_cnt_width_lp'(1);
                end else begin
                    state_d   = (gap_p > 0) ? GAP : IDLE;
                    gap_cnt_d = gap_last_lp;
                end
            end
            GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - gap_cnt_width_lp'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State register; reset drops the line immediately and abandons any packet.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            tag_data_q <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            tag_data_q <= tag_data_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    assign cmd_if.ready_and = (state_q == IDLE);
    assign tag_data_o       = tag_data_q;
    assign busy_o           = busy_q;
    assign err_o            = err_q;

endmodule

// File: tb/tb_bsg_tag_tx_serializer.sv
// Bench for bsg_tag_tx_serializer: one instance with a two-cycle gap and one
// with no gap share the stimulus; only the selected instance sees v.
module tb_bsg_tag_tx_serializer;
    import bsg_tag_tx_pkg::*;

    localparam int els_lp  = 7;
    localparam int maxp_lp = 3;
    localparam int gap_lp  = 2;

    typedef struct packed {
        logic [2:0] node_id;
        logic       dnr;
        logic [1:0] len;
        logic [2:0] payload;
    } cmd_t;

    typedef struct {
        cmd_t       cmd;
        logic [9:0] bits;
        int         n;
        logic       err;
    } vec_t;

    logic clk;
    logic rst;
    logic drv_v;
    logic [2:0] drv_node_id;
    logic drv_dnr;
    logic [1:0] drv_len;
    logic [2:0] drv_payload;
    logic use_gap0;
    logic tag2, busy2, err2, tag0, busy0, err0;
    logic obs_tag, obs_busy, obs_ready, obs_err;

    int errors = 0;
    int checks = 0;

    vec_t       tbl[6];
    cmd_t       cmd_q[$];
    logic [3:0] exp_q[$];

    bsg_tag_tx_serializer_if if_g2();
    bsg_tag_tx_serializer_if if_g0();

    assign if_g2.v              = drv_v & ~use_gap0;
    assign if_g2.node_id        = drv_node_id;
    assign if_g2.data_not_reset = drv_dnr;
    assign if_g2.len            = drv_len;
    assign if_g2.payload        = drv_payload;
    assign if_g0.v              = drv_v & use_gap0;
    assign if_g0.node_id        = drv_node_id;
    assign if_g0.data_not_reset = drv_dnr;
    assign if_g0.len            = drv_len;
    assign if_g0.payload        = drv_payload;

    assign obs_tag   = use_gap0 ? tag0 : tag2;
    assign obs_busy  = use_gap0 ? busy0 : busy2;
    assign obs_ready = use_gap0 ? if_g0.ready_and : if_g2.ready_and;
    assign obs_err   = use_gap0 ? err0 : err2;

    bsg_tag_tx_serializer #(.els_p(els_lp), .max_payload_width_p(maxp_lp), .gap_p(gap_lp)) dut_g2 (
        .clk_i(clk), .reset_i(rst), .cmd_if(if_g2),
        .tag_data_o(tag2), .busy_o(busy2), .err_o(err2));

    bsg_tag_tx_serializer #(.els_p(els_lp), .max_payload_width_p(maxp_lp), .gap_p(0)) dut_g0 (
        .clk_i(clk), .reset_i(rst), .cmd_if(if_g0),
        .tag_data_o(tag0), .busy_o(busy0), .err_o(err0));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int idx, input logic [3:0] expv);
        logic [3:0] act;
        act = {obs_tag, obs_busy, obs_ready, obs_err};
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s[%0d]: tag/busy/ready/err got %b expected %b", name, idx, act, expv);
        end
    endtask

    task automatic applyStimulus(input cmd_t c);
        drv_v       = 1'b1;
        drv_node_id = c.node_id;
        drv_dnr     = c.dnr;
        drv_len     = c.len;
        drv_payload = c.payload;
    endtask

    task automatic setVec(input int i, input logic [2:0] node, input logic dnr, input logic [1:0] len,
                          input logic [2:0] pay, input logic [9:0] bits, input int n, input logic err);
        tbl[i].cmd  = {node, dnr, len, pay};
        tbl[i].bits = bits;
        tbl[i].n    = n;
        tbl[i].err  = err;
    endtask

    // Expected per-cycle trace from a hand-derived table entry.
    task automatic tableExpect(input vec_t v, input int gap);
        if (v.err) begin
            exp_q.push_back(4'b0011);
        end else begin
            for (int k = 0; k < v.n; k++) exp_q.push_back({v.bits[k], 3'b100});
            for (int k = 0; k < gap; k++) exp_q.push_back(4'b0100);
            exp_q.push_back(4'b0010);
        end
    endtask

    // Reference model: builds the serial bit list field by field from the
    // protocol rules, then appends the gap and the idle accept cycle.
    task automatic modelCommand(input cmd_t c, input int gap);
        int bl[$];
        if (int'(c.node_id) >= els_lp || int'(c.len) > maxp_lp) begin
            exp_q.push_back(4'b0011);
            return;
        end
        bl.push_back(1);
        for (int i = 0; i < 2; i++) bl.push_back((int'(c.len) >> i) % 2);
        bl.push_back(int'(c.dnr));
        for (int i = 0; i < 3; i++) bl.push_back((int'(c.node_id) >> i) % 2);
        for (int i = 0; i < int'(c.len); i++) bl.push_back((int'(c.payload) >> i) % 2);
        foreach (bl[i]) exp_q.push_back({bl[i][0], 3'b100});
        for (int k = 0; k < gap; k++) exp_q.push_back(4'b0100);
        exp_q.push_back(4'b0010);
    endtask

    // Holds v high with the head command, advancing only after a cycle in
    // which ready was seen, and compares every cycle against exp_q.
    task automatic runStream(input string name);
        int  idx;
        bit  pend;
        @(negedge clk);
        checkOutput({name, "_idle"}, 0, 4'b0010);
        idx = 0;
        if (cmd_q.size() > 0) applyStimulus(cmd_q[0]);
        pend = drv_v && obs_ready;
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            if (pend) begin
                idx++;
                if (idx < cmd_q.size()) applyStimulus(cmd_q[idx]);
                else drv_v = 1'b0;
            end
            checkOutput(name, k, exp_q[k]);
            pend = drv_v && obs_ready;
        end
        drv_v = 1'b0;
        cmd_q.delete();
        exp_q.delete();
    endtask

    initial begin
        cmd_t c;
        rst = 1'b1;
        drv_v = 1'b0;
        drv_node_id = '0;
        drv_dnr = 1'b0;
        drv_len = '0;
        drv_payload = '0;
        use_gap0 = 1'b0;

        // Serial vectors: bit k of bits is the k-th bit on the line.
        setVec(0, 3'd5, 1'b1, 2'd2, 3'b010, 10'b0101011101, 9, 1'b0);
        setVec(1, 3'd0, 1'b0, 2'd0, 3'b000, 10'b0000000001, 7, 1'b0);
        setVec(2, 3'd3, 1'b1, 2'd3, 3'b101, 10'b1010111111, 10, 1'b0);
        setVec(3, 3'd7, 1'b1, 2'd1, 3'b001, 10'b0000000000, 0, 1'b1);
        setVec(4, 3'd2, 1'b1, 2'd1, 3'b110, 10'b0000101011, 8, 1'b0);
        setVec(5, 3'd6, 1'b0, 2'd2, 3'b111, 10'b0111100101, 9, 1'b0);

        repeat (3) @(negedge clk);
        checkOutput("reset_g2", 0, 4'b0010);
        use_gap0 = 1'b1;
        #1 checkOutput("reset_g0", 0, 4'b0010);
        use_gap0 = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Table vectors, one packet per stream.
        for (int i = 0; i < 6; i++) begin
            cmd_q.push_back(tbl[i].cmd);
            tableExpect(tbl[i], gap_lp);
            runStream("table");
        end

        // Back-to-back with v held: three queued commands including a reject.
        cmd_q.push_back(tbl[0].cmd); tableExpect(tbl[0], gap_lp);
        cmd_q.push_back(tbl[3].cmd); tableExpect(tbl[3], gap_lp);
        cmd_q.push_back(tbl[1].cmd); tableExpect(tbl[1], gap_lp);
        runStream("b2b");

        // Reset while bit 4 is on the line, then a full packet afterwards.
        @(negedge clk);
        checkOutput("abort_idle", 0, 4'b0010);
        applyStimulus(tbl[0].cmd);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            drv_v = 1'b0;
            checkOutput("abort_bits", k, {tbl[0].bits[k], 3'b100});
        end
        #2 rst = 1'b1;
        #1 checkOutput("abort_async", 0, 4'b0010);
        @(negedge clk);
        checkOutput("abort_held", 0, 4'b0010);
        rst = 1'b0;
        cmd_q.push_back(tbl[2].cmd);
        tableExpect(tbl[2], gap_lp);
        runStream("after_abort");

        // No-gap instance: two packets back to back.
        use_gap0 = 1'b1;
        cmd_q.push_back(tbl[0].cmd); tableExpect(tbl[0], 0);
        cmd_q.push_back(tbl[1].cmd); tableExpect(tbl[1], 0);
        runStream("gap0");

        // Random streams on both instances against the reference model.
        for (int r = 0; r < 10; r++) begin
            use_gap0 = (r % 2 == 1);
            for (int j = 0; j < 4; j++) begin
                c.node_id = 3'($urandom_range(0, 7));
                c.dnr     = 1'($urandom_range(0, 1));
                c.len     = 2'($urandom_range(0, 3));
                c.payload = 3'($urandom_range(0, 7));
                cmd_q.push_back(c);
                modelCommand(c, use_gap0 ? 0 : gap_lp);
            end
            runStream("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
